load_ou_buffered: RTL

- Parametrised load operation unit for the reconfigurable accelerator, generalising the fixed-width load units to any RV32 load type via a FN3 parameter.
- Adds a constant address offset, multiple outstanding LSQ requests bounded by a credit counter, and a result FIFO with downstream acknowledge.
- Sits between the accelerator interconnect (data_in/data_out channels) and the load-store queue interface.

---
 rtl/load_ou_buffered.sv | 129 ++++++++++++
 1 files changed

// File: rtl/load_ou_buffered.sv
// rtl/load_ou_buffered.sv - parametrised LSQ load unit with credit-bounded issue and in-order result FIFO
module load_ou_buffered #(
    parameter logic [2:0]         LOAD_FN3        = 3'b101,
    parameter logic signed [31:0] ADDR_OFFSET     = 0,
    parameter int                 MAX_OUTSTANDING = 4,
    parameter int                 XLEN            = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] data_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic            data_valid_in1,
    input  logic            data_valid_in2,
    output logic            data_in_ack1,
    output logic            data_in_ack2,
    output logic            uses_data_in1,
    output logic            uses_data_in2,
    output logic [XLEN-1:0] data_out,
    output logic            data_valid_out,
    input  logic            data_out_ack,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic [2:0]      fn3,
    output logic            load,
    output logic            store,
    output logic            new_request,
    input  logic            lsq_full,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_complete,
    output logic            misaligned_err,
    output logic            protocol_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    logic [CW-1:0]   credits;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] mem [0:MAX_OUTSTANDING-1];

    logic issue;
    logic pop;
    logic accept;
    logic addr_misaligned;
    logic unused_inputs;

    assign unused_inputs = ^{data_in2, data_valid_in2};

    assign data_in_ack2  = 1'b0;
    assign uses_data_in1 = 1'b1;
    assign uses_data_in2 = 1'b0;
    assign data          = '0;
    assign fn3           = LOAD_FN3;
    assign load          = 1'b1;
    assign store         = 1'b0;

    assign addr = data_in1 + XLEN'(ADDR_OFFSET);

    // No pop bypass: a full credit pool blocks issue even while the head is popped.
    assign issue        = data_valid_in1 && !lsq_full && (credits < MAX_C) && !rst;
    assign new_request  = issue;
    assign data_in_ack1 = issue;

    assign data_valid_out = (count != '0);
    assign data_out       = data_valid_out ? mem[rd_ptr] : '0;
    assign pop            = data_valid_out && data_out_ack;
    assign accept         = load_complete && (pending != '0);

    always_comb begin
        addr_misaligned = 1'b0;
        case (LOAD_FN3[1:0])
            2'b01:   addr_misaligned = addr[0];
            2'b10:   addr_misaligned = (addr[1:0] != 2'b00);
            default: addr_misaligned = 1'b0;
        endcase
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            credits        <= '0;
            pending        <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            misaligned_err <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            if (issue && !pop)
                credits <= credits + 1'b1;
            else if (!issue && pop)
                credits <= credits - 1'b1;

            if (issue && !accept)
                pending <= pending + 1'b1;
            else if (!issue && accept)
                pending <= pending - 1'b1;

            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;

            if (accept)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);

            if (issue && addr_misaligned)
                misaligned_err <= 1'b1;
            if (load_complete && (pending == '0))
                protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst)
            mem[wr_ptr] <= load_data;
    end

endmodule
